// File: rtl/gain_stepper.sv
// Button-stepped power-of-two gain stage: synchronised, debounced level stepping
// plus a one-cycle saturating datapath with a clip flag for the panel LED.
module gain_stepper #(
  parameter int WIDTH    = 16,
  parameter int LEVELS   = 4,
  parameter int DEBOUNCE = 4,
  localparam int LVL_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Button,
  input  logic             In_valid,
  input  logic [WIDTH-1:0] Data_in,
  output logic             Out_valid,
  output logic [WIDTH-1:0] Data_out,
  output logic             Clip,
  output logic [LVL_W-1:0] volume_level
);

  localparam int PW = WIDTH + LEVELS - 1;
  localparam logic [15:0]      CNT_LAST = 16'(DEBOUNCE - 1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } btn_state_e;

  // Button FSM state, kept as a named enum so checkers can bind to it.
  btn_state_e       btn_state;
  btn_state_e       btn_state_nxt;
  logic [15:0]      cnt;
  logic [15:0]      cnt_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             press_accept;
  logic             sync_q1;
  logic             sync_q2;
  logic             s;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= Button;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_state    <= ST_IDLE;
      cnt          <= '0;
      volume_level <= '0;
    end else begin
      btn_state    <= btn_state_nxt;
      cnt          <= cnt_nxt;
      volume_level <= level_nxt;
    end
  end

  always_comb begin
    btn_state_nxt = btn_state;
    cnt_nxt       = cnt;
    case (btn_state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (s) begin
          cnt_nxt       = 16'd1;
          btn_state_nxt = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (!s) begin
          cnt_nxt       = '0;
          btn_state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt       = '0;
          btn_state_nxt = ST_HELD;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_HELD: begin
        if (!s) begin
          cnt_nxt       = 16'd1;
          btn_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (s) begin
          cnt_nxt       = '0;
          btn_state_nxt = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt       = '0;
          btn_state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        cnt_nxt       = '0;
        btn_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The level steps only on the PRESS->HELD transition, so holding never repeats.
  always_comb begin
    press_accept = (btn_state == ST_PRESS) && s && (cnt == CNT_LAST);
    level_nxt    = volume_level;
    if (press_accept) begin
      level_nxt = (volume_level == LVL_LAST) ? '0 : volume_level + LVL_W'(1);
    end
  end

  // Valid semantics: In_valid marks a sample to take this edge (no back-pressure);
  // Out_valid is high for exactly the one cycle after, with Data_out/Clip for it.
  logic signed [PW-1:0] din_ext;
  logic signed [PW-1:0] prod;
  logic [LEVELS-1:0]    prod_hi;
  logic                 ovf;

  assign din_ext = {{(LEVELS-1){Data_in[WIDTH-1]}}, Data_in};
  assign prod    = din_ext <<< volume_level;
  assign prod_hi = prod[PW-1:WIDTH-1];
  // In range only when every bit above the result's sign bit copies it.
  assign ovf     = !((&prod_hi) || !(|prod_hi));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out_valid <= 1'b0;
      Data_out  <= '0;
      Clip      <= 1'b0;
    end else if (In_valid) begin
      Out_valid <= 1'b1;
      Clip      <= ovf;
      if (ovf) begin
        Data_out <= prod_hi[LEVELS-1] ? SAT_MIN : SAT_MAX;
      end else begin
        Data_out <= prod[WIDTH-1:0];
      end
    end else begin
      Out_valid <= 1'b0;
      Clip      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gain_stepper.sv
// Directed bench for gain_stepper: reset, debounce timing, level wrap,
// saturation table and same-edge / mid-press reset corner cases.
module tb_gain_stepper;

  localparam int WIDTH    = 16;
  localparam int LEVELS   = 4;
  localparam int DEBOUNCE = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Button;
  logic        In_valid;
  logic [15:0] Data_in;
  logic        Out_valid;
  logic [15:0] Data_out;
  logic        Clip;
  logic [1:0]  volume_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic        in_valid;
    logic [15:0] din;
    logic        exp_valid;
    logic [15:0] exp_dout;
    logic        exp_clip;
  } vec_t;

  vec_t vecs[10];

  gain_stepper #(
    .WIDTH    (WIDTH),
    .LEVELS   (LEVELS),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Button       (Button),
    .In_valid     (In_valid),
    .Data_in      (Data_in),
    .Out_valid    (Out_valid),
    .Data_out     (Data_out),
    .Clip         (Clip),
    .volume_level (volume_level)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic press_release(input int hi, input int lo);
    Button = 1'b1;
    repeat (hi) tick();
    Button = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    // Level-3 table: gain x8 with saturation on both rails.
    vecs[0] = '{1'b1, 16'h0FFF, 1'b1, 16'h7FF8, 1'b0};
    vecs[1] = '{1'b1, 16'h1000, 1'b1, 16'h7FFF, 1'b1};
    vecs[2] = '{1'b1, 16'hF000, 1'b1, 16'h8000, 1'b0};
    vecs[3] = '{1'b1, 16'hEFFF, 1'b1, 16'h8000, 1'b1};
    vecs[4] = '{1'b0, 16'h1111, 1'b0, 16'h8000, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFF8, 1'b0};
    vecs[6] = '{1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    vecs[7] = '{1'b1, 16'h8000, 1'b1, 16'h8000, 1'b1};
    vecs[8] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[9] = '{1'b0, 16'h5555, 1'b0, 16'h0000, 1'b0};

    Reset    = 1'b1;
    Button   = 1'b0;
    In_valid = 1'b0;
    Data_in  = '0;
    repeat (3) tick();
    chk("rst_valid", Out_valid, 0);
    chk("rst_dout", Data_out, 0);
    chk("rst_clip", Clip, 0);
    chk("rst_level", volume_level, 0);
    Reset = 1'b0;

    In_valid = 1'b1;
    Data_in  = 16'h1234;
    tick();
    chk("first_valid", Out_valid, 1);
    chk("first_dout", Data_out, 16'h1234);
    chk("first_clip", Clip, 0);
    chk("first_level", volume_level, 0);
    In_valid = 1'b0;

    // Held 10 cycles: exactly one step, landing at edge DEBOUNCE+1.
    Button = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("press_lvl", volume_level, (e >= DEBOUNCE + 1) ? 1 : 0);
    end
    Button = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("release_lvl", volume_level, 1);
    end

    press_release(8, 8);
    chk("step_2", volume_level, 2);
    press_release(8, 8);
    chk("step_3", volume_level, 3);

    for (int i = 0; i < 10; i++) begin
      In_valid = vecs[i].in_valid;
      Data_in  = vecs[i].din;
      exp_q.push_back(vecs[i].exp_dout);
      tick();
      chk("tbl_valid", Out_valid, vecs[i].exp_valid);
      chk("tbl_dout", Data_out, exp_q.pop_front());
      chk("tbl_clip", Clip, vecs[i].exp_clip);
    end
    In_valid = 1'b0;

    press_release(8, 8);
    chk("wrap_0", volume_level, 0);

    press_release(3, 8);
    chk("glitch_hi", volume_level, 0);

    Button = 1'b1;
    repeat (8) tick();
    chk("drop_press", volume_level, 1);
    Button = 1'b0;
    repeat (2) tick();
    Button = 1'b1;
    repeat (8) tick();
    chk("drop_held", volume_level, 1);
    Button = 1'b0;
    repeat (8) tick();
    chk("drop_release", volume_level, 1);

    press_release(8, 8);
    press_release(8, 8);
    press_release(8, 8);
    chk("back_to_0", volume_level, 0);

    // Press acceptance and a sample share an edge: sample uses the old level.
    Button = 1'b1;
    repeat (DEBOUNCE + 1) tick();
    chk("same_pre_lvl", volume_level, 0);
    In_valid = 1'b1;
    Data_in  = 16'h0100;
    tick();
    chk("same_dout", Data_out, 16'h0100);
    chk("same_valid", Out_valid, 1);
    chk("same_lvl", volume_level, 1);
    tick();
    chk("next_dout", Data_out, 16'h0200);
    In_valid = 1'b0;
    tick();
    chk("idle_valid", Out_valid, 0);
    chk("idle_hold", Data_out, 16'h0200);
    chk("idle_clip", Clip, 0);
    Button = 1'b0;
    repeat (8) tick();

    In_valid = 1'b1;
    Data_in  = 16'h0300;
    Button   = 1'b1;
    repeat (4) tick();
    chk("midpress_dout", Data_out, 16'h0600);
    chk("midpress_lvl", volume_level, 1);
    Reset = 1'b1;
    tick();
    chk("mrst_lvl", volume_level, 0);
    chk("mrst_valid", Out_valid, 0);
    chk("mrst_dout", Data_out, 0);
    chk("mrst_clip", Clip, 0);
    Reset    = 1'b0;
    In_valid = 1'b0;
    // Button still high after reset: counted afresh from IDLE.
    for (int e = 0; e < 6; e++) begin
      tick();
      chk("post_rst_lvl", volume_level, (e >= DEBOUNCE + 1) ? 1 : 0);
    end
    Button = 1'b0;
    repeat (8) tick();
    chk("post_rst_final", volume_level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gain_stepper.md
# gain_stepper

Parametrised, button-stepped digital gain stage for the pedal-board audio path, placed between the codec receive interface and the effect chain. It replaces the fixed four-level 16-bit gain block. Additions over that block:
- Signed samples of any width and any number of power-of-two gain levels.
- Synchronised, debounced press/release detection.
- Valid-qualified one-cycle datapath with correct two's-complement saturation and a clip flag for the front-panel LED.

## Interface
Parameters:
- WIDTH, 16, sample width (signed two's complement); legal range 8..32.
- LEVELS, 4, number of gain settings; level n applies gain 2^n; legal range 2..WIDTH-1.
- DEBOUNCE, 4, consecutive synchronised cycles required to accept a press or a release; legal range 2..65535.
- LVL_W, derived, $clog2(LEVELS) (minimum 1); not overridden by the instantiator.

Ports:
- Clk  input  1  system clock; reset Reset, synchronous, active-high; clock Clk.
- Reset  input  1  synchronous active-high reset.
- Button  input  1  raw front-panel push button, asynchronous, active-high.
- In_valid  input  1  Data_in holds a new sample this cycle.
- Data_in  input  WIDTH  signed input sample.
- Out_valid  output  1  Data_out holds a new sample this cycle.
- Data_out  output  WIDTH  signed, gained, saturated sample.
- Clip  output  1  high with Out_valid when the current output saturated.
- volume_level  output  LVL_W  current gain level, 0..LEVELS-1.

## Operation
- Button passes through a 2-flop synchroniser; the result is s. The FSM and debounce counter (16-bit) use s only.
- Button FSM states and transitions:
  - IDLE: cnt=0. If s=1, cnt<=1 and go to PRESS.
  - PRESS: if s=0, cnt<=0 and go to IDLE; level unchanged. Else if cnt==DEBOUNCE-1, accept the press: volume_level <= (volume_level==LEVELS-1) ? 0 : volume_level+1; cnt<=0; go to HELD. Else cnt++.
  - HELD: if s=0, cnt<=1 and go to RELEASE.
  - RELEASE: if s=1, cnt<=0 and go to HELD. Else if cnt==DEBOUNCE-1, cnt<=0 and go to IDLE. Else cnt++.
  - A level increments exactly once per debounced press/release cycle; holding the button never auto-repeats.
- Datapath, on a cycle with In_valid=1:
  - Compute p = Data_in * 2^volume_level at full WIDTH+LEVELS-1 precision.
  - If p > 2^(WIDTH-1)-1: Data_out <= 2^(WIDTH-1)-1 and Clip<=1.
  - If p < -2^(WIDTH-1): Data_out <= -2^(WIDTH-1) and Clip<=1.
  - Otherwise Data_out <= p[WIDTH-1:0] and Clip<=0.
  - Out_valid<=1.
- On a cycle with In_valid=0: Out_valid<=0 and Clip<=0. Data_out holds its last value.
- The datapath uses the registered volume_level. When a level change and In_valid fall on the same edge, that sample uses the old level, and the next sample uses the new level.

## Timing
- Reset values: Data_out=0, Out_valid=0, Clip=0, volume_level=0. FSM goes to IDLE with cnt=0, and both synchroniser flops are cleared.
- Reset has priority over every other input. A reset asserted during PRESS, HELD or RELEASE discards the press.
- If Button is still high after reset deasserts, it is treated as a new press and counted from IDLE.
- Datapath latency is exactly 1 cycle from In_valid to Out_valid. Throughput is one sample per cycle, including back-to-back In_valid.
- Press latency: if Button is first sampled high at edge 0 and held, volume_level updates at edge DEBOUNCE+1.
- Release: Button must be low for DEBOUNCE synchronised cycles before the FSM returns to IDLE and the next press can be counted.
- A glitch shorter than DEBOUNCE synchronised cycles, in either direction, causes no level change.

## Test plan
Bench parameters: WIDTH=16, LEVELS=4, DEBOUNCE=4.
- Reset, then In_valid=1 with Data_in=0x1234 -> next cycle Out_valid=1, Data_out=0x1234, Clip=0, volume_level=0.
- Button high from edge 0 for 10 cycles, then low for 10 cycles -> volume_level becomes 1 at edge 5 and stays 1; no second increment.
- Four full press/release cycles -> volume_level steps 1, 2, 3, 0 (wrap-around).
- At level 3, stream Data_in = 0x0FFF, 0x1000, 0xF000, 0xEFFF -> outputs 0x7FF8 Clip=0; 0x7FFF Clip=1; 0x8000 Clip=0; 0x8000 Clip=1.
- Button pulses high for 3 cycles only -> no level change. Pressed-state Button drops low for 2 cycles -> no extra increment.
- Debounced press completes on the same edge as In_valid with Data_in=0x0100 at level 0 -> that output is 0x0100; the following sample 0x0100 outputs 0x0200. Reset asserted mid-PRESS -> volume_level=0 and all outputs at reset values.
